// File: rtl/uram_access_arbiter.sv
// Shares one simple-dual-port URAM between two writers (port A) and two readers (port B); registered memory commands.
// Grants are combinational, commands issue one clock later, read data returns RD_LATENCY clocks after that; clients hold req until granted.
module uram_access_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 3100,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w0_req,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  output logic                  w0_gnt,
  input  logic                  w1_req,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  output logic                  w1_gnt,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  output logic                  mem_enb,
  output logic [ADDR_WIDTH-1:0] mem_addrb,
  input  logic [DATA_WIDTH-1:0] mem_doutb,
  output logic                  err_oob
);

  typedef struct packed {
    logic vld;
    logic id;
    logic oob;
  } tag_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DATA_DEPTH);

  logic                  w_ptr, r_ptr;
  logic                  w_any, w_id, w_oob;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  r_any, r_id, r_oob, r_blk, r_acc;
  logic [ADDR_WIDTH-1:0] r_addr;
  tag_t                  tag_new, tag_out;
  tag_t [RD_LATENCY:0]   tag_q;
  logic [DATA_WIDTH-1:0] rdata_m;

  always_comb begin
    // Round-robin: a lone requester wins, otherwise the pointer picks.
    w_any  = (w0_req | w1_req) & ~rst;
    w_id   = (w0_req & w1_req) ? w_ptr : w1_req;
    w_addr = w_id ? w1_addr : w0_addr;
    w_data = w_id ? w1_data : w0_data;
    w_oob  = {1'b0, w_addr} >= DEPTH_LIM;

    r_any  = (r0_req | r1_req) & ~rst;
    r_id   = (r0_req & r1_req) ? r_ptr : r1_req;
    r_addr = r_id ? r1_addr : r0_addr;
    r_oob  = {1'b0, r_addr} >= DEPTH_LIM;
    // The memory is read-first, so a same-address read must wait one cycle
    // to observe this write; the other reader is deliberately not promoted.
    r_blk  = w_any & (r_addr == w_addr);
    r_acc  = r_any & ~r_blk;

    w0_gnt = w_any & ~w_id;
    w1_gnt = w_any & w_id;
    r0_gnt = r_acc & ~r_id;
    r1_gnt = r_acc & r_id;

    tag_new.vld = r_acc;
    tag_new.id  = r_id;
    tag_new.oob = r_oob;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wea   <= 1'b0;
      mem_addra <= '0;
      mem_dina  <= '0;
      mem_enb   <= 1'b0;
      mem_addrb <= '0;
      err_oob   <= 1'b0;
      w_ptr     <= 1'b0;
      r_ptr     <= 1'b0;
      tag_q     <= '0;
    end else begin
      mem_wea <= w_any & ~w_oob;
      if (w_any && !w_oob) begin
        mem_addra <= w_addr;
        mem_dina  <= w_data;
      end
      mem_enb <= r_acc & ~r_oob;
      if (r_acc && !r_oob) begin
        mem_addrb <= r_addr;
      end
      err_oob <= (w_any & w_oob) | (r_acc & r_oob);
      if (w_any) begin
        w_ptr <= ~w_id;
      end
      if (r_acc) begin
        r_ptr <= ~r_id;
      end
      tag_q[0] <= tag_new;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    tag_out   = tag_q[RD_LATENCY];
    // Out-of-range reads never touched the memory, so their data is zeroed.
    rdata_m   = tag_out.oob ? '0 : mem_doutb;
    r0_rvalid = tag_out.vld & ~tag_out.id;
    r1_rvalid = tag_out.vld & tag_out.id;
    r0_rdata  = r0_rvalid ? rdata_m : '0;
    r1_rdata  = r1_rvalid ? rdata_m : '0;
  end

endmodule

// File: doc/uram_access_arbiter.md
Name: uram_access_arbiter

Overview:
- Shares the single 64-bit URAM simple-dual-port buffer between two write clients on port A and two read clients on port B.
- Write clients are, for example, game-logic and init/clear; read clients are, for example, the display scanner and collision check.
- Round-robin grants on each port, a registered memory command interface, and a tag pipeline that returns read data to the owning client.
- Blocks same-address read/write collisions so every read sees the newest data, and drops out-of-range accesses.

Parameters:
- ADDR_WIDTH, 14, address width of clients and memory ports.
- DATA_WIDTH, 64, data word width.
- DATA_DEPTH, 3100, number of valid words; addresses >= DATA_DEPTH are out of range.
- RD_LATENCY, 2, memory read latency in clocks, from address sample to doutb valid.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- w0_req / w1_req  in  1  write request; held until granted.
- w0_addr / w1_addr  in  ADDR_WIDTH  write address.
- w0_data / w1_data  in  DATA_WIDTH  write data.
- w0_gnt / w1_gnt  out  1  combinational; req&gnt = write accepted this cycle.
- r0_req / r1_req  in  1  read request; held until granted.
- r0_addr / r1_addr  in  ADDR_WIDTH  read address.
- r0_gnt / r1_gnt  out  1  combinational; req&gnt = read accepted.
- r0_rvalid / r1_rvalid  out  1  one-cycle pulse, read data valid.
- r0_rdata / r1_rdata  out  DATA_WIDTH  read data, meaningful only while rvalid.
- mem_wea  out  1  registered memory write enable.
- mem_addra  out  ADDR_WIDTH  registered write address.
- mem_dina  out  DATA_WIDTH  registered write data.
- mem_enb  out  1  registered read enable.
- mem_addrb  out  ADDR_WIDTH  registered read address.
- mem_doutb  in  DATA_WIDTH  memory read data.
- err_oob  out  1  registered pulse, an out-of-range access was accepted.

Behaviour:
- Reset values:
  - mem_wea, mem_enb, err_oob = 0.
  - mem_addra, mem_addrb, mem_dina = 0.
  - All rvalid = 0; tag pipeline cleared.
  - Both round-robin pointers point to client 0.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced for them.
- Write arbitration:
  - One write per cycle.
  - If only one client requests, it is granted.
  - If both request, the client not granted last is granted.
  - The write pointer updates only on an accepted write.
- Read arbitration: same round-robin scheme with an independent pointer.
- Collision rule:
  - Applies when the read client selected by round-robin has the same address as the write granted this cycle.
  - That read gets no grant this cycle; the read pointer does not move.
  - The other read client is not granted in its place.
  - The blocked read is granted the next cycle (memory is read_first; this guarantees new data).
- Write path:
  - A write accepted in cycle c drives mem_wea=1 with its address and data in cycle c+1.
  - Out-of-range write (addr >= DATA_DEPTH): accepted, mem_wea stays 0, err_oob=1 in c+1.
- Read path:
  - A read accepted in cycle c drives mem_enb=1 with mem_addrb in cycle c+1.
  - The owning client's rvalid is asserted in cycle c+1+RD_LATENCY (c+3 at default).
  - rdata is mem_doutb passed through combinationally.
- Tag pipeline:
  - Shift register of depth RD_LATENCY+1 carrying {valid, client id, oob}.
  - Advances every cycle; the read path is fully pipelined, one read per cycle sustained.
- Out-of-range read: accepted, mem_enb stays 0, err_oob=1 in c+1, rvalid still fires at c+3 with rdata forced to 0.
- Non-owning client: rdata = 0, rvalid = 0.
- Simultaneous in-range read and write in one cycle (different addresses): both granted, both issued in c+1.
- Idle: mem_wea/mem_enb = 0; mem_addra/mem_addrb/mem_dina hold their last values.

Test Plan:
- Reset, then w0 writes addr 5 = 0xA5A5; r1 reads addr 5 two cycles later -> r1_rvalid exactly 3 cycles after r1 grant, r1_rdata = 0xA5A5, r0_rvalid stays 0.
- r0 and r1 both hold requests for 6 cycles (addr 1 / addr 2) -> grants alternate r0,r1,r0,r1,r0,r1; rvalid pulses alternate with 3-cycle offset, back-to-back.
- w0 writes addr 7 = 0x1111 while r0 requests addr 7 in the same cycle -> r0_gnt = 0 that cycle, granted next cycle, r0_rdata = 0x1111.
- w1 writes addr 3100 -> w1_gnt = 1, mem_wea never asserts, err_oob pulses once; r0 reads addr 4000 -> rvalid at c+3, r0_rdata = 0, err_oob pulses.
- Issue 2 reads, assert rst for 1 cycle in c+1 -> no rvalid afterwards; after reset, w0 and w1 requesting together -> w0 granted first.
